// File: rtl/clock_tick_scheduler.sv
// Timebase controller: one-cycle fast/slow clock-enable ticks plus square waves on the
// system clock, with divisors reloadable at run time at period boundaries.
module clock_tick_scheduler #(
  parameter int unsigned FAST_DIV = 200000,
  parameter int unsigned SLOW_DIV = 100,
  parameter int unsigned CNT_W    = 25
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic             cfg_sel,
  input  logic [CNT_W-1:0] cfg_div,
  output logic             cfg_err,
  output logic             tick_fast,
  output logic             tick_slow,
  output logic             sq_fast,
  output logic             sq_slow
);

  typedef enum logic [1:0] {StStop, StRun, StPend} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] fast_div_q, fast_div_d;
  logic [CNT_W-1:0] slow_div_q, slow_div_d;
  logic [CNT_W-1:0] fast_cnt_q, fast_cnt_d;
  logic [CNT_W-1:0] slow_cnt_q, slow_cnt_d;
  logic [CNT_W-1:0] pend_div_q, pend_div_d;
  logic             pend_sel_q, pend_sel_d;
  logic             alive_q;
  logic             counting, term_f, term_s, xfer, div_ok, pend_wrap;

  // Gating with run makes every output drop in the cycle after run is sampled low.
  assign counting  = (state_q != StStop) && run;
  assign term_f    = counting && (fast_cnt_q == fast_div_q - CNT_W'(1));
  assign term_s    = term_f && (slow_cnt_q == slow_div_q - CNT_W'(1));
  // alive_q keeps cfg_ready low until the first edge after reset release.
  assign cfg_ready = alive_q && (state_q != StPend);
  assign xfer      = cfg_valid && cfg_ready;
  assign div_ok    = cfg_div >= CNT_W'(2);
  assign pend_wrap = pend_sel_q ? term_s : term_f;

  always_comb begin
    state_d    = state_q;
    fast_div_d = fast_div_q;
    slow_div_d = slow_div_q;
    pend_div_d = pend_div_q;
    pend_sel_d = pend_sel_q;
    fast_cnt_d = '0;
    slow_cnt_d = '0;

    if (counting) begin
      fast_cnt_d = term_f ? '0 : fast_cnt_q + CNT_W'(1);
      if (term_s) begin
        slow_cnt_d = '0;
      end else if (term_f) begin
        slow_cnt_d = slow_cnt_q + CNT_W'(1);
      end else begin
        slow_cnt_d = slow_cnt_q;
      end
    end

    unique case (state_q)
      StStop: begin
        if (xfer && div_ok) begin
          if (cfg_sel) slow_div_d = cfg_div;
          else         fast_div_d = cfg_div;
        end
        if (run) state_d = StRun;
      end
      StRun: begin
        if (!run) begin
          state_d = StStop;
          if (xfer && div_ok) begin
            if (cfg_sel) slow_div_d = cfg_div;
            else         fast_div_d = cfg_div;
          end
        end else if (xfer && div_ok) begin
          pend_sel_d = cfg_sel;
          pend_div_d = cfg_div;
          state_d    = StPend;
        end
      end
      StPend: begin
        // Load on the wrap of the pending channel so no period is ever truncated or stretched.
        if (!run || pend_wrap) begin
          if (pend_sel_q) slow_div_d = pend_div_q;
          else            fast_div_d = pend_div_q;
          state_d = run ? StRun : StStop;
        end
      end
      default: state_d = StStop;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StStop;
      fast_div_q <= CNT_W'(FAST_DIV);
      slow_div_q <= CNT_W'(SLOW_DIV);
      fast_cnt_q <= '0;
      slow_cnt_q <= '0;
      pend_div_q <= '0;
      pend_sel_q <= 1'b0;
      alive_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      fast_div_q <= fast_div_d;
      slow_div_q <= slow_div_d;
      fast_cnt_q <= fast_cnt_d;
      slow_cnt_q <= slow_cnt_d;
      pend_div_q <= pend_div_d;
      pend_sel_q <= pend_sel_d;
      alive_q    <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tick_fast <= 1'b0;
      tick_slow <= 1'b0;
      sq_fast   <= 1'b0;
      sq_slow   <= 1'b0;
      cfg_err   <= 1'b0;
    end else begin
      tick_fast <= term_f;
      tick_slow <= term_s;
      sq_fast   <= counting && (fast_cnt_q < (fast_div_q >> 1));
      sq_slow   <= counting && (slow_cnt_q < (slow_div_q >> 1));
      cfg_err   <= xfer && !div_ok;
    end
  end

endmodule

// File: tb/tb_clock_tick_scheduler.sv
// Directed bench for clock_tick_scheduler with a small divisor set; expected output
// vectors are queued per cycle and compared once the DUT has clocked.
module tb_clock_tick_scheduler;

  localparam int unsigned CntW = 8;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            run = 1'b0;
  logic            cfg_valid = 1'b0;
  logic            cfg_sel = 1'b0;
  logic [CntW-1:0] cfg_div = '0;
  logic            cfg_ready, cfg_err, tick_fast, tick_slow, sq_fast, sq_slow;
  logic [5:0]      obs;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [5:0] val;
    string      tag;
  } exp_t;

  exp_t sb[$];

  clock_tick_scheduler #(
    .FAST_DIV(4),
    .SLOW_DIV(3),
    .CNT_W   (CntW)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .run      (run),
    .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready),
    .cfg_sel  (cfg_sel),
    .cfg_div  (cfg_div),
    .cfg_err  (cfg_err),
    .tick_fast(tick_fast),
    .tick_slow(tick_slow),
    .sq_fast  (sq_fast),
    .sq_slow  (sq_slow)
  );

  always #5 clk = ~clk;

  // Bit order: tick_fast, tick_slow, sq_fast, sq_slow, cfg_ready, cfg_err
  assign obs = {tick_fast, tick_slow, sq_fast, sq_slow, cfg_ready, cfg_err};

  task automatic check(input string tag, input logic [5:0] e);
    n_checks++;
    assert (obs === e) else begin
      n_errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, e);
    end
  endtask

  task automatic push(input logic [5:0] e, input string tag);
    exp_t x;
    x.val = e;
    x.tag = tag;
    sb.push_back(x);
  endtask

  task automatic pop_check();
    exp_t x;
    x = sb.pop_front();
    check(x.tag, x.val);
  endtask

  // Queue the expectation for the coming edge, clock once, compare away from the edge.
  task automatic cyc(input logic [5:0] e, input string tag);
    push(e, tag);
    @(posedge clk);
    #1;
    pop_check();
  endtask

  // Expected outputs m edges after a point where both counters were zero (slow at s0).
  task automatic exp_reg(input int fd, input int sd, input int s0, input int m,
                         input logic rdy, input logic err, input string tag);
    int   fc, sc;
    logic tk, ts, sq, sqs;
    fc  = (m - 1) % fd;
    sc  = (s0 + (m - 1) / fd) % sd;
    tk  = (fc == fd - 1);
    ts  = tk && (sc == sd - 1);
    sq  = fc < fd / 2;
    sqs = sc < sd / 2;
    cyc({tk, ts, sq, sqs, rdy, err}, $sformatf("%s_m%0d", tag, m));
  endtask

  task automatic cfg(input logic sel, input int div);
    cfg_valid = 1'b1;
    cfg_sel   = sel;
    cfg_div   = CntW'(div);
  endtask

  initial begin
    // Reset and idle
    #2 reset = 1'b1;
    #1;
    push(6'b000000, "reset_async");
    pop_check();
    cyc(6'b000000, "reset_held0");
    cyc(6'b000000, "reset_held1");
    reset = 1'b0;
    cyc(6'b000010, "idle0");
    cyc(6'b000010, "idle1");

    // Steady state fast=4, slow=3
    run = 1'b1;
    cyc(6'b000010, "start_e0");
    for (int n = 1; n <= 24; n++) exp_reg(4, 3, 0, n, 1'b1, 1'b0, "steady");

    // Bad divisor: accepted, flagged, ignored
    cfg(1'b0, 1);
    exp_reg(4, 3, 0, 25, 1'b1, 1'b1, "bad_cfg");
    cfg_valid = 1'b0;
    for (int n = 26; n <= 37; n++) exp_reg(4, 3, 0, n, 1'b1, 1'b0, "after_bad");

    // Fast reload to 6 at fast_cnt=1; old period still ends at 4
    cfg(1'b0, 6);
    exp_reg(4, 3, 0, 38, 1'b0, 1'b0, "fast_pend");
    cfg_valid = 1'b0;
    exp_reg(4, 3, 0, 39, 1'b0, 1'b0, "fast_pend");
    exp_reg(4, 3, 0, 40, 1'b1, 1'b0, "fast_reload");
    for (int m = 1; m <= 18; m++) exp_reg(6, 3, 1, m, 1'b1, 1'b0, "fast6");

    // Slow reload to 2 mid-frame; current frame completes with 3 fast ticks
    cfg(1'b1, 2);
    exp_reg(6, 3, 1, 19, 1'b0, 1'b0, "slow_pend");
    cfg_valid = 1'b0;
    for (int m = 20; m <= 29; m++) exp_reg(6, 3, 1, m, 1'b0, 1'b0, "slow_pend");
    exp_reg(6, 3, 1, 30, 1'b1, 1'b0, "slow_reload");
    for (int k = 1; k <= 26; k++) exp_reg(6, 2, 0, k, 1'b1, 1'b0, "slow2");

    // Stop at fast_cnt=2 with a simultaneous slow write, then a direct fast write in STOP
    run = 1'b0;
    cfg(1'b1, 3);
    cyc(6'b000010, "stop_xfer");
    cfg_valid = 1'b0;
    cyc(6'b000010, "stopped1");
    cfg(1'b0, 4);
    cyc(6'b000010, "stop_load");
    cfg_valid = 1'b0;
    cyc(6'b000010, "stopped3");
    cyc(6'b000010, "stopped4");
    run = 1'b1;
    cyc(6'b000010, "restart_e0");
    for (int m = 1; m <= 24; m++) exp_reg(4, 3, 0, m, 1'b1, 1'b0, "restart");

    // Reset while a fast reload is pending: pending value must be discarded
    cfg(1'b0, 6);
    exp_reg(4, 3, 0, 25, 1'b0, 1'b0, "pend_before_reset");
    cfg_valid = 1'b0;
    reset = 1'b1;
    #1;
    push(6'b000000, "reset_in_pend");
    pop_check();
    cyc(6'b000000, "reset_pend_held");
    reset = 1'b0;
    cyc(6'b000010, "post_reset_e0");
    for (int m = 1; m <= 12; m++) exp_reg(4, 3, 0, m, 1'b1, 1'b0, "post_reset");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
